alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 8-bit ALU between NREQ requesters, e.g. the fetch/decode
//  unit and the branch unit. Arbitrates round-robin and registers the operands.
//  Sequences each op through a fixed IDLE->EXEC->RESP flow.
//  Returns result, carry and zero on a shared response bus with a one-hot valid.
//  Latches a sticky halt when an HLT op (4'b0000) completes.
// PARAMETERS
//  NREQ    2  number of requesters (2..4); index 0 = lowest index
//  DATA_W  8  operand/result width; must match the ALU
//  OP_W    4  ALU control width; must match the ALU
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous reset, active low
//  req_valid  in   NREQ         request i pending
//  req_ready  out  NREQ         one-hot accept; transfer when valid&ready
//  req_op     in   NREQ*OP_W    op of requester i at [i*OP_W +: OP_W]
//  req_a      in   NREQ*DATA_W  operand A of requester i
//  req_b      in   NREQ*DATA_W  operand B of requester i
//  rsp_valid  out  NREQ         one-hot: response belongs to requester i
//  rsp_ready  in   NREQ         requester i consumes the response
//  rsp_res    out  DATA_W       registered ALU result
//  rsp_carry  out  1            registered ALU carry
//  rsp_zero   out  1            rsp_res == 0 (BEQ compare via op 4'b1111)
//  alu_a      out  DATA_W       to ALU A (operand register)
//  alu_b      out  DATA_W       to ALU B (operand register)
//  alu_ctrl   out  OP_W         to ALU control (op register)
//  alu_res    in   DATA_W       from ALU result
//  alu_carry  in   1            from ALU carry
//  halted     out  1            sticky: an HLT op has completed
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all outputs 0; op/operand regs 0; halted=0.
//   - RR pointer set so requester 0 has highest priority.
//  FSM:
//   - IDLE: if !halted and any req_valid, grant = first valid index at or after ptr,
//     wrapping. req_ready[grant]=1, combinational from req_valid in IDLE only.
//     At the edge: capture op/A/B and the grant id, then go to EXEC.
//     With no valid request, or halted=1: req_ready=0, stay in IDLE.
//   - EXEC: exactly 1 cycle; ALU driven from the registers.
//     At the edge: rsp_res<=alu_res, rsp_carry<=alu_carry, rsp_zero<=(alu_res==0).
//     If op==4'b0000, halted<=1. Go to RESP.
//   - RESP: rsp_valid[id]=1. rsp_res, rsp_carry and rsp_zero are held stable until
//     rsp_ready[id]=1. Then ptr<=id+1 (mod NREQ), go to IDLE.
//     rsp_ready of non-granted requesters is ignored.
//  Timing:
//   - Accept edge T; result registered at T+1; rsp_valid high from after T+1.
//   - Minimum 3 cycles per op; no overlap between ops.
//  Register and signal rules:
//   - The op/operand registers change only on accept.
//   - alu_* outputs hold the last op between ops.
//   - req_ready is never asserted outside IDLE or while halted.
//   - Simultaneous requests: the served index moves to lowest priority (fairness).
//  ALU semantics are not re-implemented here:
//   - DIV by 0 returns 0 and SUB borrow is reported via carry, both as the ALU supplies.
//   - Invalid ops pass through the ALU's default (res=0, carry=0).
//  HLT:
//   - The HLT response is still delivered (res=0).
//   - After it, no grants are made until reset.
//  Reset asserted mid-EXEC/RESP aborts the op: no response is given and all state
//  returns to reset values.
// TESTING
//  - Reset: rst_n=0 async mid-cycle -> all outputs 0 immediately; release -> IDLE, busy=0.
//  - ADD: req0 op=0001 A=200 B=100 -> rsp_valid=01 two edges after accept,
//    res=44 carry=1 zero=0.
//  - BEQ / DIV: req1 op=1111 A=B=0x5A -> res=0 zero=1 carry=0;
//    op=0100 A=9 B=0 -> res=0 zero=1.
//  - Contention: both req_valid held high, rsp_ready=11 -> grants 0,1,0,1;
//    each response carries the correct operands.
//  - Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=00;
//    release -> IDLE next edge.
//  - HLT: op=0000 -> response res=0, halted=1; later req_valid=11 -> req_ready stays 00
//    until reset clears halted.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between NREQ
// requesters, sequencing every op through IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_op,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]        rsp_res,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_ctrl,
  input  logic [DATA_W-1:0]        alu_res,
  input  logic                     alu_carry,
  output logic                     halted,
  output logic                     busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [OP_W-1:0] OP_HLT = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    id_q;
  logic [IDX_W-1:0]    grant;
  logic                grant_vld;
  logic [IDX_W:0]      scan_idx;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                accept;
  logic                release_rsp;

  // Scan from the highest offset down so the closest valid index at or after
  // ptr is the last one written and therefore wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (scan_idx >= (IDX_W + 1)'(NREQ)) scan_idx = scan_idx - (IDX_W + 1)'(NREQ);
      if (req_valid[scan_idx[IDX_W-1:0]]) begin
        grant     = scan_idx[IDX_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response is consumed on the edge where rsp_valid[i] & rsp_ready[i]. Ready
  // on the other bits of either bus has no effect.
  assign accept      = (state == S_IDLE) && !halted && grant_vld;
  assign release_rsp = (state == S_RESP) && rsp_ready[id_q];

  always_comb begin
    req_ready = '0;
    req_ready[grant] = accept && rst_n;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[id_q] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (release_rsp) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        id_q <= grant;
        op_q <= req_op[int'(grant)*OP_W +: OP_W];
        a_q  <= req_a[int'(grant)*DATA_W +: DATA_W];
        b_q  <= req_b[int'(grant)*DATA_W +: DATA_W];
      end
      if (state == S_EXEC) begin
        rsp_res   <= alu_res;
        rsp_carry <= alu_carry;
        rsp_zero  <= (alu_res == '0);
        if (op_q == OP_HLT) halted <= 1'b1;
      end
      // The requester just served drops to lowest priority.
      if (release_rsp) begin
        if (id_q == IDX_W'(NREQ - 1)) ptr <= '0;
        else                          ptr <= id_q + IDX_W'(1);
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and random ops against a stub ALU, with a
// round-robin/halt reference model kept as plain integers.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int OW   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OW-1:0]  req_op;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [DW-1:0]       rsp_res;
  logic                rsp_carry;
  logic                rsp_zero;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [OW-1:0]       alu_ctrl;
  logic [DW-1:0]       alu_res;
  logic                alu_carry;
  logic                halted;
  logic                busy;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int ptr_m    = 0;
  bit halted_m = 1'b0;

  logic [OW-1:0] op_t [NREQ];
  logic [DW-1:0] a_t  [NREQ];
  logic [DW-1:0] b_t  [NREQ];

  alu_arbiter #(.NREQ(NREQ), .DATA_W(DW), .OP_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .alu_carry (alu_carry),
    .halted    (halted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stub ALU: {carry, result}. SUB/BEQ report borrow on carry, DIV by 0 gives 0.
  function automatic logic [DW:0] alu_f(input logic [OW-1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW:0] r;
    r = '0;
    case (op)
      4'b0001:          r = {1'b0, a} + {1'b0, b};
      4'b0010, 4'b1111: r = {1'b0, a} - {1'b0, b};
      4'b0011:          r = {1'b0, a & b};
      4'b0100:          r = (b == '0) ? '0 : {1'b0, a / b};
      4'b0101:          r = {1'b0, a | b};
      4'b0110:          r = {1'b0, a ^ b};
      default:          r = '0;
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_res} = alu_f(alu_ctrl, alu_a, alu_b);

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_op[i*OW +: OW] = op_t[i];
      req_a[i*DW +: DW]  = a_t[i];
      req_b[i*DW +: DW]  = b_t[i];
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < NREQ; i++) begin
      op_t[i] = OW'($urandom);
      a_t[i]  = DW'($urandom);
      b_t[i]  = DW'($urandom);
    end
    drive_ops();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp"}, 32'({rsp_res, rsp_carry, rsp_zero}), 32'(0));
    check({tag, "_alu"}, 32'({alu_a, alu_b, alu_ctrl}), 32'(0));
    check({tag, "_halted"}, 32'(halted), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // One complete transaction: offer vmask, follow the granted op through
  // EXEC and RESP, hold off rsp_ready for `stall` cycles, then release.
  task automatic serve(input logic [NREQ-1:0] vmask, input int stall);
    int              g;
    logic [NREQ-1:0] gh;
    logic [DW:0]     exp;
    logic [OW-1:0]   cop;
    logic [DW-1:0]   ca;
    logic [DW-1:0]   cb;
    @(negedge clk);
    req_valid = vmask;
    rsp_ready = '0;
    drive_ops();
    #1;
    g  = halted_m ? -1 : pick(vmask, ptr_m);
    gh = (g < 0) ? '0 : (NREQ'(1) << g);
    check("req_ready_idle", 32'(req_ready), 32'(gh));
    if (g < 0) return;
    cop = op_t[g];
    ca  = a_t[g];
    cb  = b_t[g];
    exp = alu_f(cop, ca, cb);

    @(negedge clk);
    scramble_inputs();
    #1;
    check("exec_busy", 32'(busy), 32'(1));
    check("exec_alu_ctrl", 32'(alu_ctrl), 32'(cop));
    check("exec_alu_ab", 32'({alu_a, alu_b}), 32'({ca, cb}));
    check("exec_req_ready", 32'(req_ready), 32'(0));
    check("exec_rsp_valid", 32'(rsp_valid), 32'(0));

    @(negedge clk);
    if (cop == '0) halted_m = 1'b1;
    check("resp_valid", 32'(rsp_valid), 32'(gh));
    check("resp_res", 32'(rsp_res), 32'(exp[DW-1:0]));
    check("resp_carry", 32'(rsp_carry), 32'(exp[DW]));
    check("resp_zero", 32'(rsp_zero), 32'(exp[DW-1:0] == '0));
    check("resp_halted", 32'(halted), 32'(halted_m));

    for (int s = 0; s < stall; s++) begin
      rsp_ready = NREQ'($urandom) & ~gh;
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'(gh));
      check("stall_rsp", 32'({rsp_res, rsp_carry, rsp_zero}),
            32'({exp[DW-1:0], exp[DW], exp[DW-1:0] == '0}));
      check("stall_req_ready", 32'(req_ready), 32'(0));
    end

    rsp_ready = gh | NREQ'($urandom);
    @(negedge clk);
    check("release_busy", 32'(busy), 32'(0));
    check("release_rsp_valid", 32'(rsp_valid), 32'(0));
    check("release_hold_res", 32'(rsp_res), 32'(exp[DW-1:0]));
    ptr_m     = (g + 1) % NREQ;
    req_valid = '0;
    rsp_ready = '0;
  endtask

  // Reset mid-op: the op is dropped and every output clears without a clock edge.
  task automatic abort_mid(input bit in_resp);
    @(negedge clk);
    op_t[0] = 4'b0001;
    a_t[0]  = 8'd3;
    b_t[0]  = 8'd4;
    drive_ops();
    req_valid = 2'b01;
    rsp_ready = '0;
    @(negedge clk);
    req_valid = '0;
    check("abort_busy", 32'(busy), 32'(1));
    if (in_resp) begin
      @(negedge clk);
      check("abort_in_resp", 32'(rsp_valid), 32'(2'b01));
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n    = 1'b1;
    ptr_m    = 0;
    halted_m = 1'b0;
    #1 check("abort_no_rsp", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_t[i] = '0;
      a_t[i]  = '0;
      b_t[i]  = '0;
    end
    drive_ops();
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_reset_busy", 32'(busy), 32'(0));

    // ADD 200+100 wraps to 44 with carry
    op_t[0] = 4'b0001; a_t[0] = 8'd200; b_t[0] = 8'd100;
    serve(2'b01, 0);
    check("add_const", 32'({rsp_res, rsp_carry, rsp_zero}), 32'({8'd44, 1'b1, 1'b0}));

    // BEQ equal operands, then DIV by zero, both from requester 1
    op_t[1] = 4'b1111; a_t[1] = 8'h5A; b_t[1] = 8'h5A;
    serve(2'b10, 0);
    check("beq_const", 32'({rsp_res, rsp_carry, rsp_zero}), 32'({8'd0, 1'b0, 1'b1}));
    op_t[1] = 4'b0100; a_t[1] = 8'd9; b_t[1] = 8'd0;
    serve(2'b10, 0);
    check("div0_const", 32'({rsp_res, rsp_zero}), 32'({8'd0, 1'b1}));

    // contention: both valid, grants alternate
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_t[i] = OW'($urandom_range(1, 15));
        a_t[i]  = DW'($urandom);
        b_t[i]  = DW'($urandom);
      end
      serve(2'b11, 0);
      check("contention_order", 32'(ptr_m), 32'((n + 1) % 2));
    end

    // backpressure for 5 cycles
    op_t[0] = 4'b0010; a_t[0] = 8'd5; b_t[0] = 8'd7;
    serve(2'b01, 5);

    // random mix of masks, ops and stalls
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_t[i] = OW'($urandom_range(1, 15));
        a_t[i]  = DW'($urandom);
        b_t[i]  = DW'($urandom);
      end
      serve(NREQ'($urandom_range(1, 3)), $urandom_range(0, 3));
    end

    abort_mid(1'b0);
    abort_mid(1'b1);

    // HLT completes and is answered, then all grants stop
    op_t[0] = 4'b0000; a_t[0] = 8'd7; b_t[0] = 8'd9;
    serve(2'b01, 1);
    check("hlt_halted", 32'(halted), 32'(1));
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("halted_req_ready", 32'(req_ready), 32'(0));
      check("halted_busy", 32'(busy), 32'(0));
    end
    serve(2'b11, 0);

    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    #1 check("reset_clears_halt", 32'(halted), 32'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    ptr_m    = 0;
    halted_m = 1'b0;
    op_t[1] = 4'b0001; a_t[1] = 8'd1; b_t[1] = 8'd2;
    serve(2'b10, 0);
    check("after_halt_res", 32'(rsp_res), 32'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
